// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (CPU, UART loader) arbiter onto a single
// AHB-like bus with an IDLE/ADDR/DATA transfer sequence. Simultaneous
// requests are settled round-robin with a 1-bit last-grant pointer.
// Optional feature: define BUS_TIMEOUT_EN to abort a DATA phase after
// TO_CYC wait cycles, completing it with bus_err set.
module mem_bus_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int TO_CYC = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_done,
   input  logic          uart_req,
   input  logic          uart_we,
   input  logic [AW-1:0] uart_addr,
   input  logic [DW-1:0] uart_wdata,
   output logic          uart_done,
   output logic [DW-1:0] m_rdata,
   output logic [AW-1:0] haddr,
   output logic          hwrite,
   output logic [1:0]    htrans,
   output logic [DW-1:0] hwdata,
   input  logic [DW-1:0] hrdata,
   input  logic          hready,
   output logic          hmaster,
   output logic          bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t        r_state, w_next;
   logic          r_last;      // last granted master: 0 CPU, 1 UART
   logic          r_hmaster;
   logic [AW-1:0] r_addr;
   logic          r_we;
   logic [DW-1:0] r_wdata;
   logic          w_grant;
   logic          w_sel;       // master chosen this cycle if granting
   logic          w_timeout;
   logic          w_done;

   // Tie goes to whichever master was not served last; a lone request wins outright
   assign w_sel   = (cpu_req & uart_req) ? ~r_last : uart_req;
   assign w_grant = (r_state == S_IDLE) & (cpu_req | uart_req);

`ifdef BUS_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYC + 1);
   logic [CW-1:0] r_to_cnt;

   // Count wait cycles in DATA; cleared whenever outside DATA so each entry starts at zero
   always_ff @(posedge clk) begin
      if (rst || r_state != S_DATA) r_to_cnt <= '0;
      else if (!hready)             r_to_cnt <= r_to_cnt + 1'b1;
   end

   // Fires on the TO_CYC-th consecutive hready-low DATA cycle
   assign w_timeout = (r_state == S_DATA) & ~hready & (r_to_cnt == CW'(TO_CYC - 1));
`else
   // Without the timeout feature DATA waits on hready forever; TO_CYC has no effect
   assign w_timeout = 1'b0 & (TO_CYC > 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: one address cycle, then wait in DATA for hready or timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cpu_req | uart_req) w_next = S_ADDR;
         S_ADDR:  w_next = S_DATA;
         S_DATA:  if (hready | w_timeout) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Capture the winner's transfer on grant; holds stay put until the next grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last    <= 1'b0;
         r_hmaster <= 1'b0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
      end else if (w_grant) begin
         r_last    <= w_sel;
         r_hmaster <= w_sel;
         r_addr    <= w_sel ? uart_addr  : cpu_addr;
         r_we      <= w_sel ? uart_we    : cpu_we;
         r_wdata   <= w_sel ? uart_wdata : cpu_wdata;
      end
   end

   assign w_done    = (r_state == S_DATA) & (hready | w_timeout);
   assign cpu_done  = w_done & ~r_hmaster;
   assign uart_done = w_done &  r_hmaster;
   assign bus_err   = w_timeout;
   assign m_rdata   = hrdata;
   assign haddr     = r_addr;
   assign hwrite    = r_we;
   assign hwdata    = r_wdata;  // only meaningful in DATA
   assign hmaster   = r_hmaster;
   assign htrans    = (r_state == S_ADDR) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. Inputs change 1 ns after
// each rising edge; outputs are sampled 1 ns later, well clear of the edge.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, uart_req, uart_we, hready;
   logic [31:0] cpu_addr, cpu_wdata, uart_addr, uart_wdata, hrdata;
   logic        cpu_done, uart_done, hwrite, hmaster, bus_err;
   logic [31:0] m_rdata, haddr, hwdata;
   logic [1:0]  htrans;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(32), .DW(32), .TO_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
      .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
      .uart_wdata(uart_wdata), .uart_done(uart_done),
      .m_rdata(m_rdata), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
      .hmaster(hmaster), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else             n_pass++;
   endtask

   // Advance to 1 ns past the next rising edge
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs
   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; hready = 1'b1; hrdata = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      uart_req = 0; uart_we = 0; uart_addr = '0; uart_wdata = '0;

      // Reset state
      nxt(); nxt(); settle();
      chk("rst_htrans",  htrans,    2'b00);
      chk("rst_hmaster", hmaster,   1'b0);
      chk("rst_haddr",   haddr,     32'h0);
      chk("rst_hwrite",  hwrite,    1'b0);
      chk("rst_cdone",   cpu_done,  1'b0);
      chk("rst_udone",   uart_done, 1'b0);
      chk("rst_buserr",  bus_err,   1'b0);
      nxt(); rst = 1'b0;

      // CPU read with zero wait states: ADDR in cycle 1, done in cycle 2
      nxt(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100; hready = 1;
      hrdata = 32'hDEADBEEF; settle();
      chk("rd_c0_htrans", htrans, 2'b00);
      nxt(); settle();
      chk("rd_c1_htrans", htrans, 2'b10);
      chk("rd_c1_haddr",  haddr,  32'h0000_0100);
      chk("rd_c1_hwrite", hwrite, 1'b0);
      chk("rd_c1_cdone",  cpu_done, 1'b0);
      nxt(); settle();
      chk("rd_c2_cdone",  cpu_done, 1'b1);
      chk("rd_c2_udone",  uart_done, 1'b0);
      chk("rd_c2_rdata",  m_rdata, 32'hDEADBEEF);
      chk("rd_c2_htrans", htrans, 2'b00);
      cpu_req = 0;
      nxt(); settle();
      chk("rd_c3_cdone",  cpu_done, 1'b0);
      chk("rd_c3_htrans", htrans, 2'b00);

      // Simultaneous requests straight out of reset: UART first, then CPU
      rst = 1; nxt(); rst = 0;
      cpu_req = 1; cpu_addr = 32'h0000_0A00; uart_req = 1; uart_addr = 32'h0000_0B00;
      nxt(); settle();
      chk("rr_c1_hmaster", hmaster, 1'b1);
      chk("rr_c1_haddr",   haddr,   32'h0000_0B00);
      nxt(); settle();
      chk("rr_c2_udone", uart_done, 1'b1);
      chk("rr_c2_cdone", cpu_done,  1'b0);
      uart_req = 0;
      nxt(); settle();
      chk("rr_c3_htrans", htrans, 2'b00);
      nxt(); settle();
      chk("rr_c4_hmaster", hmaster, 1'b0);
      chk("rr_c4_haddr",   haddr,   32'h0000_0A00);
      chk("rr_c4_htrans",  htrans,  2'b10);
      nxt(); settle();
      chk("rr_c5_cdone", cpu_done,  1'b1);
      chk("rr_c5_udone", uart_done, 1'b0);
      cpu_req = 0;

      // UART write, 3 wait states; UART drops req and CPU requests mid-transfer
      nxt(); uart_req = 1; uart_we = 1; uart_addr = 32'h0000_0040;
      uart_wdata = 32'h12345678; hready = 0; settle();
      nxt(); settle();
      chk("wr_c1_hwrite",  hwrite,  1'b1);
      chk("wr_c1_haddr",   haddr,   32'h0000_0040);
      chk("wr_c1_hmaster", hmaster, 1'b1);
      for (int c = 2; c <= 4; c++) begin
         nxt();
         if (c == 3) begin uart_req = 0; cpu_req = 1; cpu_addr = 32'h0000_0C00; end
         settle();
         chk($sformatf("wr_c%0d_hwdata", c), hwdata, 32'h12345678);
         chk($sformatf("wr_c%0d_udone", c), uart_done, 1'b0);
         chk($sformatf("wr_c%0d_cdone", c), cpu_done, 1'b0);
         chk($sformatf("wr_c%0d_hmaster", c), hmaster, 1'b1);
         chk($sformatf("wr_c%0d_htrans", c), htrans, 2'b00);
         chk($sformatf("wr_c%0d_buserr", c), bus_err, 1'b0);
      end
      nxt(); hready = 1; settle();
      chk("wr_c5_udone", uart_done, 1'b1);
      chk("wr_c5_cdone", cpu_done,  1'b0);
      nxt(); settle();
      chk("wr_c6_htrans", htrans, 2'b00);
      nxt(); settle();
      chk("wr_c7_hmaster", hmaster, 1'b0);
      chk("wr_c7_haddr",   haddr,   32'h0000_0C00);
      nxt(); settle();
      chk("wr_c8_cdone", cpu_done, 1'b1);
      cpu_req = 0;

      // Reset during DATA: no done pulse, clean restart
      nxt(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0300; hready = 0;
      nxt(); nxt(); rst = 1; settle();
      nxt(); rst = 0; cpu_req = 0; hready = 1; settle();
      chk("rs_htrans",  htrans,   2'b00);
      chk("rs_cdone",   cpu_done, 1'b0);
      chk("rs_haddr",   haddr,    32'h0);
      chk("rs_hmaster", hmaster,  1'b0);
      nxt(); cpu_req = 1; cpu_addr = 32'h0000_0200; settle();
      nxt(); settle();
      chk("rs_new_htrans", htrans, 2'b10);
      chk("rs_new_haddr",  haddr,  32'h0000_0200);
      nxt(); settle();
      chk("rs_new_cdone", cpu_done, 1'b1);
      cpu_req = 0;

`ifdef BUS_TIMEOUT_EN
      // hready stuck low: abort on the 16th DATA cycle with bus_err
      nxt(); cpu_req = 1; cpu_addr = 32'h0000_0400; hready = 0; settle();
      nxt(); settle();
      for (int c = 1; c <= 15; c++) begin
         nxt(); settle();
         chk($sformatf("to_d%0d_cdone", c), cpu_done, 1'b0);
      end
      nxt(); settle();
      chk("to_d16_cdone",  cpu_done, 1'b1);
      chk("to_d16_buserr", bus_err,  1'b1);
      cpu_req = 0;
      nxt(); settle();
      chk("to_after_htrans", htrans,  2'b00);
      chk("to_after_buserr", bus_err, 1'b0);
      chk("to_after_cdone",  cpu_done, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter AW, 32: address width.
REQ-002 Parameter DW, 32: data width.
REQ-003 Parameter TO_CYC, 16: DATA-phase timeout in cycles; used only when BUS_TIMEOUT_EN is defined.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cpu_req  input  1  CPU load/store request; held high until cpu_done.
REQ-007 cpu_we  input  1  CPU write (1) / read (0).
REQ-008 cpu_addr  input  AW  CPU byte address.
REQ-009 cpu_wdata  input  DW  CPU store data.
REQ-010 cpu_done  output  1  one-cycle CPU completion pulse.
REQ-011 uart_req  input  1  UART loader request; held high until uart_done.
REQ-012 uart_we  input  1  UART write (1) / read (0).
REQ-013 uart_addr  input  AW  UART byte address.
REQ-014 uart_wdata  input  DW  UART write data.
REQ-015 uart_done  output  1  one-cycle UART completion pulse.
REQ-016 m_rdata  output  DW  read data, shared by both masters; valid only with the done pulse.
REQ-017 haddr  output  AW  bus address.
REQ-018 hwrite  output  1  bus write flag.
REQ-019 htrans  output  2  bus transfer type: 2'b10 NONSEQ, 2'b00 IDLE.
REQ-020 hwdata  output  DW  bus write data.
REQ-021 hrdata  input  DW  bus read data.
REQ-022 hready  input  1  bus data-phase complete.
REQ-023 hmaster  output  1  current owner: 0 CPU, 1 UART.
REQ-024 bus_err  output  1  timeout abort flag, coincident with the done pulse.

Function
REQ-025 FSM states: IDLE, ADDR, DATA. Transitions: IDLE->ADDR on any request; ADDR->DATA unconditionally; DATA->IDLE when hready=1 (or on timeout).
REQ-026 In IDLE, a single request is granted; on simultaneous requests the master not served last is granted (round-robin via a 1-bit last pointer that updates on each grant).
REQ-027 On grant, register the selected master's addr, we and wdata, plus hmaster; these holds stay stable until the next grant.
REQ-028 In ADDR, htrans=2'b10; in all other states htrans=2'b00; haddr and hwrite always drive the registered values.
REQ-029 hwdata drives the registered wdata in DATA; its value in other states is don't-care.
REQ-030 done = (state==DATA) & hready, routed to the granted master only; m_rdata = hrdata combinationally.
REQ-031 Latency: request seen in IDLE at cycle 0 -> done in cycle 2 with zero wait states; each hready=0 cycle in DATA adds one cycle.
REQ-032 A master that drops req mid-transaction: the transfer still completes and done still pulses.
REQ-033 Back-to-back: the cycle after done, the FSM is in IDLE and re-arbitrates; a master must drop req on done to avoid an immediate re-grant.
REQ-034 No second grant while the FSM is not in IDLE; a request arriving then waits.

Reset
REQ-035 On rst: state=IDLE, last pointer=CPU (UART wins the first tie), hmaster=0, htrans=2'b00, haddr/hwrite/holds=0, done pulses=0, bus_err=0, timeout counter=0.
REQ-036 rst asserted mid-transaction aborts it with no done pulse; the next cycle is IDLE.

Configuration
REQ-037 Macro BUS_TIMEOUT_EN defined: a counter runs in DATA; if hready stays 0 for TO_CYC consecutive cycles, pulse done for the granted master with bus_err=1 for that cycle, then go to IDLE; the counter clears on entry to DATA.
REQ-038 Macro undefined: DATA waits on hready indefinitely; bus_err is tied to 0; the port exists in both builds.

Verification
REQ-039 CPU read addr 0x0000_0100, hready=1, hrdata=0xDEADBEEF -> htrans=10 in cycle 1, cpu_done with m_rdata=0xDEADBEEF in cycle 2.
REQ-040 cpu_req and uart_req rise together after reset, each dropping req on its done -> UART granted first, then CPU; hmaster=1 then 0.
REQ-041 UART write 0x0000_0040 / 0x12345678 with hready low for 3 cycles -> hwdata=0x12345678 held, uart_done in cycle 5, cpu_done stays 0.
REQ-042 BUS_TIMEOUT_EN, TO_CYC=16, hready stuck low -> cpu_done with bus_err=1 after 16 DATA cycles, then IDLE.
REQ-043 rst pulsed during DATA -> no done pulse, htrans=00, and a new request is granted normally after reset.
